gemm_acc_array: RTL

GEMM_ACC_ARRAY -- requirements
Module: gemm_acc_array

---
 rtl/gemm_pkg.sv | 30 +++
 rtl/gemm_dot.sv | 29 ++
 rtl/gemm_acc_array.sv | 130 +++++++++++++
 3 files changed

// File: rtl/gemm_pkg.sv
// rtl/gemm_pkg.sv - shared widths, beat/counter derivation and FSM states for gemm_acc_array
package gemm_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 32;
  localparam int DEF_ARRAY_N    = 16;
  localparam int DEF_ARRAY_M    = 4;
  localparam int DEF_CHANNEL    = 96;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  // Number of beats needed to cover one reduction.
  function automatic int beats_of(input int channel, input int array_n);
    return channel / array_n;
  endfunction

  // Beat counter width; a single-beat reduction still needs one bit.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Width that holds an exact ARRAY_N-element signed dot product.
  function automatic int dot_width(input int data_width, input int array_n);
    return 2 * data_width + ((array_n > 1) ? $clog2(array_n) : 0);
  endfunction

endpackage

// File: rtl/gemm_dot.sv
// rtl/gemm_dot.sv - one column: combinational full-precision signed dot product
module gemm_dot
  import gemm_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ARRAY_N    = DEF_ARRAY_N,
  parameter int DOT_W      = dot_width(DEF_DATA_WIDTH, DEF_ARRAY_N)
) (
  input  logic [ARRAY_N*DATA_WIDTH-1:0] inp,
  input  logic [ARRAY_N*DATA_WIDTH-1:0] wgt,
  output logic signed [DOT_W-1:0]       dot
);

  logic signed [DOT_W-1:0] ea;
  logic signed [DOT_W-1:0] eb;

  // Sign-extend each element pair to the result width so products and sums are exact.
  always_comb begin
    dot = '0;
    ea  = '0;
    eb  = '0;
    for (int i = 0; i < ARRAY_N; i++) begin
      ea  = DOT_W'($signed(inp[i*DATA_WIDTH +: DATA_WIDTH]));
      eb  = DOT_W'($signed(wgt[i*DATA_WIDTH +: DATA_WIDTH]));
      dot = dot + ea * eb;
    end
  end

endmodule

// File: rtl/gemm_acc_array.sv
// rtl/gemm_acc_array.sv - multi-beat signed GEMM accumulator array; GEMM_ACC_SAT_EN selects saturating accumulation
module gemm_acc_array
  import gemm_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int ARRAY_N    = DEF_ARRAY_N,
  parameter int ARRAY_M    = DEF_ARRAY_M,
  parameter int CHANNEL    = DEF_CHANNEL
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clear,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [ARRAY_N*DATA_WIDTH-1:0]         inp,
  input  logic [ARRAY_M*ARRAY_N*DATA_WIDTH-1:0] wgt,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [ARRAY_M*ACC_WIDTH-1:0]          out_data,
  output logic [ARRAY_M-1:0]                    overflow
);

  localparam int BEATS  = beats_of(CHANNEL, ARRAY_N);
  localparam int CNT_W  = cnt_width(BEATS);
  localparam int DOT_W  = dot_width(DATA_WIDTH, ARRAY_N);
  localparam int WIDE_W = ((ACC_WIDTH > DOT_W) ? ACC_WIDTH : DOT_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

`ifdef GEMM_ACC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic                    accept;
  logic                    take;
  logic signed [DOT_W-1:0]     dot     [ARRAY_M];
  logic signed [ACC_WIDTH-1:0] acc     [ARRAY_M];
  logic signed [ACC_WIDTH-1:0] acc_nxt [ARRAY_M];
  logic signed [WIDE_W-1:0]    wide    [ARRAY_M];
  logic [ARRAY_M-1:0]          add_ovf;
  logic [ARRAY_M-1:0]          ovf;

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  for (genvar m = 0; m < ARRAY_M; m++) begin : g_col
    gemm_dot #(
      .DATA_WIDTH (DATA_WIDTH),
      .ARRAY_N    (ARRAY_N),
      .DOT_W      (DOT_W)
    ) u_dot (
      .inp (inp),
      .wgt (wgt[m*ARRAY_N*DATA_WIDTH +: ARRAY_N*DATA_WIDTH]),
      .dot (dot[m])
    );
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // Next state: clear wins, last accepted beat finishes, consumer handshake returns.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (accept && (cnt == LAST_BEAT)) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = ACCUM;
        default: state_nxt = ACCUM;
      endcase
    end
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DONE);
  end

  // Beat counter wraps on the final beat of a reduction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (clear)              cnt <= '0;
    else if (accept)             cnt <= (cnt == LAST_BEAT) ? '0 : cnt + 1'b1;
  end

  // Exact-width add per column; out-of-range results flag overflow and wrap or clamp.
  always_comb begin
    add_ovf = '0;
    for (int m = 0; m < ARRAY_M; m++) begin
      wide[m]    = WIDE_W'(acc[m]) + WIDE_W'(dot[m]);
      add_ovf[m] = (wide[m] != WIDE_W'($signed(wide[m][ACC_WIDTH-1:0])));
      acc_nxt[m] = wide[m][ACC_WIDTH-1:0];
`ifdef GEMM_ACC_SAT_EN
      if (add_ovf[m]) acc_nxt[m] = wide[m][WIDE_W-1] ? ACC_MIN : ACC_MAX;
`endif
    end
  end

  // Accumulators and sticky overflow: cleared on abort or on result hand-off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < ARRAY_M; m++) acc[m] <= '0;
      ovf <= '0;
    end else if (clear || take) begin
      for (int m = 0; m < ARRAY_M; m++) acc[m] <= '0;
      ovf <= '0;
    end else if (accept) begin
      for (int m = 0; m < ARRAY_M; m++) acc[m] <= acc_nxt[m];
      ovf <= ovf | add_ovf;
    end
  end

  // Flatten the column accumulators onto the result bus.
  always_comb begin
    out_data = '0;
    for (int m = 0; m < ARRAY_M; m++) out_data[m*ACC_WIDTH +: ACC_WIDTH] = acc[m];
  end

  assign overflow = ovf;

endmodule
